uart_tx_fifo_drain: RTL and testbench

UART transmit serializer that sits directly downstream of the TX fifo.
- Pops bytes from the fifo read port (re / rd / fifo_emp).
- Frames each byte as start + 8 data bits (LSB first) + 1 or 2 stop bits, and drives the serial line.
- The fifo read data is combinational from its read pointer, so a byte is valid whenever fifo_emp=0.

---
 rtl/uart_pkg.sv | 9 +
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_fifo_drain.sv | 142 ++++++++++++++
 tb/tb_uart_tx_fifo_drain.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared state encoding and line constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_st_e;

   localparam int   UART_DATA_W   = 8;
   localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick generator: divider value captured at frame start, counter runs 0..comp_q and wraps.
module uart_baud_gen #(
   parameter int div_w = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load,
   input  logic             clear,
   input  logic [div_w-1:0] comp,
   output logic             tick
);

   logic [div_w-1:0] comp_q;
   logic [div_w-1:0] cnt;

   assign tick = (cnt == comp_q);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         comp_q <= '0;
         cnt    <= '0;
      end else begin
         if (load) begin
            comp_q <= comp;
         end
         if (clear || tick) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that pops bytes from a TX fifo and serializes them (8N1 / 8N2).
// Define UART_TX_PARITY_EN to add the par_en/par_odd ports and a parity bit after the data.
module uart_tx_fifo_drain
   import uart_pkg::*;
#(
   parameter int div_w = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             tr_en,
   input  logic [div_w-1:0] comp,
   input  logic             stop_bits,
   input  logic             fifo_emp,
   input  logic [7:0]       rd,
`ifdef UART_TX_PARITY_EN
   input  logic             par_en,
   input  logic             par_odd,
`endif
   output logic             re,
   output logic             uart_tx,
   output logic             busy,
   output logic             tx_done
);

   uart_tx_st_e            state;
   uart_tx_st_e            state_next;
   logic [UART_DATA_W-1:0] shift_reg;
   logic [2:0]             bit_cnt;
   logic                   stop2_q;
   logic                   stop_cnt;
   logic                   tick;
   logic                   clear;
   logic                   line_lvl;
   logic                   pop;
`ifdef UART_TX_PARITY_EN
   logic                   par_en_q;
   logic                   par_q;
`endif

   // Counter restarts on every state change, and is held at zero while idle.
   assign clear = (state_next != state) || (state == IDLE);
   assign busy  = (state != IDLE);
   assign pop   = (state == IDLE) && tr_en && !fifo_emp;

   uart_baud_gen #(.div_w(div_w)) u_baud (
      .clk   (clk),
      .rstn  (rstn),
      .load  (pop),
      .clear (clear),
      .comp  (comp),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      re         = 1'b0;
      tx_done    = 1'b0;
      line_lvl   = UART_IDLE_LVL;
      case (state)
         IDLE: begin
            re = pop;
            if (pop) begin
               state_next = START;
            end
         end
         START: begin
            line_lvl = 1'b0;
            if (tick) begin
               state_next = DATA;
            end
         end
         DATA: begin
            line_lvl = shift_reg[0];
            if (tick && (bit_cnt == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
               state_next = par_en_q ? PARITY : STOP;
`else
               state_next = STOP;
`endif
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            line_lvl = par_q;
            if (tick) begin
               state_next = STOP;
            end
         end
`endif
         STOP: begin
            if (tick && (!stop2_q || stop_cnt)) begin
               tx_done    = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Line level is registered from the current state, so it trails the state by one clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         uart_tx   <= UART_IDLE_LVL;
         shift_reg <= '0;
         bit_cnt   <= '0;
         stop2_q   <= 1'b0;
         stop_cnt  <= 1'b0;
      end else begin
         uart_tx <= line_lvl;
         if (pop) begin
            shift_reg <= rd;
            bit_cnt   <= '0;
            stop2_q   <= stop_bits;
         end else if ((state == DATA) && tick) begin
            shift_reg <= shift_reg >> 1;
            bit_cnt   <= bit_cnt + 3'd1;
         end
         stop_cnt <= (state == STOP) && (tick || stop_cnt);
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
      end else if (pop) begin
         par_en_q <= par_en;
         par_q    <= par_odd ? ~^rd : ^rd;
      end
   end
`endif

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Bench for uart_tx_fifo_drain: frame table, hand-written corner sequences and random
// traffic compared every cycle against a frame-level model. Honours UART_TX_PARITY_EN.
module tb_uart_tx_fifo_drain;

   localparam int DIV_W = 16;
   localparam int LOG_N = 8192;

   logic             clk = 1'b0;
   logic             rstn;
   logic             tr_en;
   logic [DIV_W-1:0] comp;
   logic             stop_bits;
   logic             fifo_emp;
   logic [7:0]       rd;
   logic             par_en;
   logic             par_odd;
   logic             re;
   logic             uart_tx;
   logic             busy;
   logic             tx_done;

   uart_tx_fifo_drain #(.div_w(DIV_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .tr_en     (tr_en),
      .comp      (comp),
      .stop_bits (stop_bits),
      .fifo_emp  (fifo_emp),
      .rd        (rd),
`ifdef UART_TX_PARITY_EN
      .par_en    (par_en),
      .par_odd   (par_odd),
`endif
      .re        (re),
      .uart_tx   (uart_tx),
      .busy      (busy),
      .tx_done   (tx_done)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_errors = 0;
   int         cyc = 0;
   logic [7:0] fifo_q[$];
   logic       line_log [LOG_N];
   logic       busy_log [LOG_N];
   int         re_q[$];
   int         done_q[$];

   // Frame-level reference: one record per frame, the line is a list of bits of m_p clocks each.
   bit          m_active = 1'b0;
   int          m_k = 0;
   int          m_len = 0;
   int          m_p = 1;
   logic [11:0] m_bits = '1;
   logic        m_prev_lvl = 1'b1;

   typedef struct {
      logic [7:0]  data;
      int          comp;
      logic        stop2;
      int          nbits;
      int          exp_busy;
      logic [11:0] exp_frame;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int build_frame(input logic [7:0] d, input logic s2, input logic pe,
                                      input logic po, output logic [11:0] fr);
      int n;
      fr    = '1;
      fr[0] = 1'b0;
      for (int i = 0; i < 8; i++) fr[1+i] = d[i];
      n = 9;
      if (pe) begin
         fr[n] = (^d) ^ po;
         n++;
      end
      n += s2 ? 2 : 1;
      return n;
   endfunction

   task automatic refresh();
      fifo_emp = (fifo_q.size() == 0);
      rd       = fifo_emp ? 8'h00 : fifo_q[0];
   endtask

   task automatic sample();
      logic e_re, e_busy, e_done, e_tx, lvl;
      int   nb;
      cyc++;
      if (cyc < LOG_N) begin
         line_log[cyc] = uart_tx;
         busy_log[cyc] = busy;
      end
      if (re === 1'b1) re_q.push_back(cyc);
      if (tx_done === 1'b1) done_q.push_back(cyc);
      if (!rstn) begin
         m_active   = 1'b0;
         m_prev_lvl = 1'b1;
         e_re = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_tx = 1'b1;
      end else begin
         if (m_active) begin
            m_k++;
            if (m_k > m_len) m_active = 1'b0;
         end
         if (m_active) begin
            e_re   = 1'b0;
            e_busy = 1'b1;
            e_done = (m_k == m_len);
            lvl    = m_bits[(m_k-1)/m_p];
         end else begin
            e_busy = 1'b0;
            e_done = 1'b0;
            e_re   = tr_en & ~fifo_emp;
            lvl    = 1'b1;
            if (e_re) begin
               m_active = 1'b1;
               m_k      = 0;
               m_p      = int'(comp) + 1;
               nb       = build_frame(rd, stop_bits, par_en, par_odd, m_bits);
               m_len    = nb * m_p;
            end
         end
         e_tx       = m_prev_lvl;
         m_prev_lvl = lvl;
      end
      chk("re", re, e_re);
      chk("busy", busy, e_busy);
      chk("tx_done", tx_done, e_done);
      chk("uart_tx", uart_tx, e_tx);
   endtask

   // One clock: check at the falling edge, then apply the fifo pop after the rising edge.
   task automatic step();
      logic pop;
      @(negedge clk);
      sample();
      pop = (re === 1'b1);
      @(posedge clk);
      #1;
      if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
   endtask

   task automatic send_frame(input logic [7:0] d, input int c, input logic s2, output int t0);
      int n0;
      int budget;
      n0        = re_q.size();
      comp      = c[DIV_W-1:0];
      stop_bits = s2;
      fifo_q.push_back(d);
      refresh();
      tr_en  = 1'b1;
      budget = 0;
      while (re_q.size() == n0 && budget < 50) begin
         step();
         budget++;
      end
      tr_en = 1'b0;
      chk("re_wait", re_q.size() - n0, 1);
      if (re_q.size() == n0) begin
         t0 = -1;
      end else begin
         t0 = re_q[n0];
         repeat (12*(c+1)+4) step();
      end
   endtask

   initial begin
      int          t0, t1, n0, d0, budget, cnt, p;
      logic [11:0] cap;

      vecs[0] = '{8'hA5, 3, 1'b0, 10, 40, 12'hF4A};
      vecs[1] = '{8'h3C, 1, 1'b1, 11, 22, 12'hE78};
      vecs[2] = '{8'hFF, 0, 1'b0, 10, 10, 12'hFFE};
      vecs[3] = '{8'h00, 2, 1'b1, 11, 33, 12'hE00};
      vecs[4] = '{8'h5A, 5, 1'b0, 10, 60, 12'hEB4};

      rstn = 1'b1; tr_en = 1'b0; comp = 16'd3; stop_bits = 1'b0;
      par_en = 1'b0; par_odd = 1'b0;
      refresh();
      #2 rstn = 1'b0;
      #1;
      chk("rst_uart_tx", uart_tx, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_re", re, 1'b0);
      chk("rst_tx_done", tx_done, 1'b0);
      step();
      step();
      rstn = 1'b1;
      step();

      // Frame table: decode the line at bit centres and measure busy/tx_done timing.
      for (int v = 0; v < 5; v++) begin
         d0 = done_q.size();
         send_frame(vecs[v].data, vecs[v].comp, vecs[v].stop2, t0);
         if (t0 >= 0) begin
            p   = vecs[v].comp + 1;
            cap = '1;
            for (int j = 0; j < vecs[v].nbits; j++) cap[j] = line_log[t0+2+j*p+p/2];
            chk("frame_bits", cap, vecs[v].exp_frame);
            cnt = 0;
            for (int c = t0; c <= t0 + vecs[v].exp_busy + 2; c++) cnt += int'(busy_log[c]);
            chk("busy_len", cnt, vecs[v].exp_busy);
            chk("done_count", done_q.size() - d0, 1);
            if (done_q.size() > d0) chk("done_cycle", done_q[d0] - t0, vecs[v].exp_busy);
         end
      end

      // Back-to-back frames at comp=0: one idle cycle between them.
      comp = 16'd0; stop_bits = 1'b0;
      n0 = re_q.size();
      fifo_q.push_back(8'h01);
      fifo_q.push_back(8'h80);
      refresh();
      tr_en  = 1'b1;
      budget = 0;
      while (re_q.size() < n0 + 2 && budget < 60) begin
         step();
         budget++;
      end
      tr_en = 1'b0;
      repeat (15) step();
      chk("b2b_pops", re_q.size() - n0, 2);
      if (re_q.size() >= n0 + 2) begin
         t0 = re_q[n0];
         t1 = re_q[n0+1];
         chk("b2b_re_gap", t1 - t0, 11);
         chk("b2b_idle_busy", busy_log[t0+11], 1'b0);
         chk("b2b_gap_line", line_log[t0+12], 1'b1);
         chk("b2b_start2", line_log[t0+13], 1'b0);
         chk("b2b_msb2", line_log[t1+10], 1'b1);
      end

      // Empty fifo with tr_en high: nothing happens.
      n0 = re_q.size();
      tr_en = 1'b1;
      repeat (100) step();
      chk("empty_no_pop", re_q.size() - n0, 0);
      cnt = 0;
      for (int c = cyc - 99; c <= cyc; c++) cnt += int'(busy_log[c]) + int'(!line_log[c]);
      chk("empty_idle", cnt, 0);

      // tr_en low with data waiting, then tr_en dropped mid-frame.
      tr_en = 1'b0;
      fifo_q.push_back(8'h3A);
      refresh();
      repeat (20) step();
      chk("tr_en_off_no_pop", re_q.size() - n0, 0);
      comp = 16'd2;
      d0 = done_q.size();
      tr_en  = 1'b1;
      budget = 0;
      while (re_q.size() == n0 && budget < 20) begin
         step();
         budget++;
      end
      repeat (3) step();
      tr_en = 1'b0;
      fifo_q.push_back(8'hC3);
      refresh();
      repeat (40) step();
      chk("midframe_pops", re_q.size() - n0, 1);
      chk("midframe_done", done_q.size() - d0, 1);
      fifo_q.delete();
      refresh();

`ifdef UART_TX_PARITY_EN
      par_en = 1'b1;
      par_odd = 1'b0;
      d0 = done_q.size();
      send_frame(8'h07, 1, 1'b0, t0);
      if (t0 >= 0) chk("parity_even", line_log[t0+2+9*2+1], 1'b1);
      if (done_q.size() > d0) chk("parity_len", done_q[d0] - t0, 22);
      par_odd = 1'b1;
      send_frame(8'h07, 1, 1'b0, t0);
      if (t0 >= 0) chk("parity_odd", line_log[t0+2+9*2+1], 1'b0);
      par_en = 1'b0;
      par_odd = 1'b0;
`endif

      // Asynchronous reset during data bit 3 of an all-zero byte.
      comp = 16'd3;
      stop_bits = 1'b0;
      n0 = re_q.size();
      fifo_q.push_back(8'h00);
      refresh();
      tr_en  = 1'b1;
      budget = 0;
      while (re_q.size() == n0 && budget < 20) begin
         step();
         budget++;
      end
      tr_en = 1'b0;
      repeat (17) step();
      chk("pre_reset_busy", busy, 1'b1);
      chk("pre_reset_line", uart_tx, 1'b0);
      #2 rstn = 1'b0;
      #1;
      chk("async_reset_line", uart_tx, 1'b1);
      chk("async_reset_busy", busy, 1'b0);
      step();
      step();
      rstn = 1'b1;
      tr_en = 1'b1;
      n0 = re_q.size();
      repeat (30) step();
      chk("post_reset_no_pop", re_q.size() - n0, 0);
      cnt = 0;
      for (int c = cyc - 29; c <= cyc; c++) cnt += int'(line_log[c]);
      chk("post_reset_line", cnt, 30);

      // Random traffic with divider, stop bits and enable changing underneath frames.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 3) == 0) comp = 16'($urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) stop_bits = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) tr_en = ($urandom_range(0, 3) != 0);
`ifdef UART_TX_PARITY_EN
         if ($urandom_range(0, 15) == 0) par_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 15) == 0) par_odd = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 19) == 0 && fifo_q.size() < 4) fifo_q.push_back(8'($urandom_range(0, 255)));
         refresh();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
